// File: rtl/snd_pkg.sv
// Shared defaults and constants for the sound-CPU mailbox.
// Parameter defaults live here so every file agrees on them.
package snd_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF  = PTR_W_DEF + 1;
    localparam logic [3:0] COMM_REG_ADDR = 4'b1010;
endpackage

// File: rtl/snd_fifo.sv
// Command FIFO for the sound mailbox: storage, wrapping pointers and count.
// The head output is registered and holds its last value while the queue is empty.
module snd_fifo
    import snd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              accepted,
    output logic              dropped
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;
    logic              full;
    logic              empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    // A pop frees a slot in the same cycle, so a push at full still lands.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign accepted = do_push;
    assign dropped  = push && !do_push;

    always_ff @(posedge main_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (!empty) begin
                dout <= mem[rd_ptr];
            end
        end
    end
endmodule

// File: rtl/snd_mailbox.sv
// 68K-to-Z80 sound command mailbox with IRQ generation and a one-byte reply path.
// Commands are queued in a FIFO, or in a single overwrite latch for legacy boards.
module snd_mailbox
    import snd_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter bit LATCH_MODE = 1'b0,
    parameter bit AUTO_IRQ   = 1'b0,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              snd_dt,
    input  logic              snd_on,
    input  logic [DATA_W-1:0] snd_din,
    input  logic              z80_rd,
    input  logic              z80_iorq_n,
    output logic [DATA_W-1:0] z80_dout,
    output logic              z80_int_n,
    output logic [CNT_W-1:0]  cmd_count,
    output logic              overflow,
    input  logic              reply_wr,
    input  logic [DATA_W-1:0] reply_din,
    input  logic              reply_rd,
    output logic [DATA_W-1:0] reply_dout,
    output logic              reply_valid
);
    logic dt_prev;
    logic on_prev;
    logic dt_armed;
    logic on_armed;
    logic push_req;
    logic on_rise;
    logic push_accepted;
    logic push_dropped;

    // A strobe held high through reset stays disarmed until it is seen low.
    assign push_req = snd_dt & ~dt_prev & dt_armed;
    assign on_rise  = snd_on & ~on_prev & on_armed;

    always_ff @(posedge main_clk) begin
        if (reset) begin
            dt_prev  <= 1'b0;
            on_prev  <= 1'b0;
            dt_armed <= ~snd_dt;
            on_armed <= ~snd_on;
        end else begin
            dt_prev  <= snd_dt;
            on_prev  <= snd_on;
            dt_armed <= dt_armed | ~snd_dt;
            on_armed <= on_armed | ~snd_on;
        end
    end

    generate
        if (LATCH_MODE) begin : g_latch
            logic [DATA_W-1:0] latch_q;
            logic              latch_full;

            always_ff @(posedge main_clk) begin
                if (reset) begin
                    latch_q    <= '0;
                    latch_full <= 1'b0;
                end else if (push_req) begin
                    latch_q    <= snd_din;
                    latch_full <= 1'b1;
                end else if (z80_rd) begin
                    latch_full <= 1'b0;
                end
            end

            assign z80_dout      = latch_q;
            assign cmd_count     = {{(CNT_W-1){1'b0}}, latch_full};
            assign push_accepted = push_req;
            assign push_dropped  = 1'b0;
        end else begin : g_fifo
            snd_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .main_clk (main_clk),
                .reset    (reset),
                .push     (push_req),
                .pop      (z80_rd),
                .din      (snd_din),
                .dout     (z80_dout),
                .count    (cmd_count),
                .accepted (push_accepted),
                .dropped  (push_dropped)
            );
        end
    endgenerate

    // Acknowledge wins over a trigger arriving in the same cycle.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            z80_int_n <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            if (!z80_iorq_n) begin
                z80_int_n <= 1'b1;
            end else if (on_rise || (AUTO_IRQ && push_accepted)) begin
                z80_int_n <= 1'b0;
            end
            if (push_dropped) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            reply_dout  <= '0;
            reply_valid <= 1'b0;
        end else if (reply_wr) begin
            reply_dout  <= reply_din;
            reply_valid <= 1'b1;
        end else if (reply_rd) begin
            reply_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_snd_mailbox.sv
// Scoreboard bench for snd_mailbox: a FIFO instance and a latch/auto-IRQ instance.
// Stimulus queues hand-computed expectations; a negedge monitor retires them.
module tb_snd_mailbox;
    localparam int K_DOUT   = 0;
    localparam int K_COUNT  = 1;
    localparam int K_OVF    = 2;
    localparam int K_INTN   = 3;
    localparam int K_RDOUT  = 4;
    localparam int K_RVALID = 5;
    localparam int K_LDOUT  = 6;
    localparam int K_LCOUNT = 7;
    localparam int K_LOVF   = 8;
    localparam int K_LINTN  = 9;

    logic       main_clk = 1'b0;
    logic       reset = 1'b1;
    logic       snd_dt = 1'b0;
    logic       snd_on = 1'b0;
    logic [7:0] snd_din = 8'h00;
    logic       z80_rd = 1'b0;
    logic       z80_iorq_n = 1'b1;
    logic       reply_wr = 1'b0;
    logic [7:0] reply_din = 8'h00;
    logic       reply_rd = 1'b0;
    logic       l_dt = 1'b0;
    logic       l_rd = 1'b0;

    logic [7:0] z80_dout;
    logic       z80_int_n;
    logic [2:0] cmd_count;
    logic       overflow;
    logic [7:0] reply_dout;
    logic       reply_valid;
    logic [7:0] l_dout;
    logic       l_int_n;
    logic [2:0] l_count;
    logic       l_overflow;
    logic [7:0] l_reply_dout;
    logic       l_reply_valid;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          kind_q[$];
    int unsigned val_q[$];
    int unsigned due_q[$];
    string       name_q[$];

    always #5 main_clk = ~main_clk;
    always @(posedge main_clk) cyc <= cyc + 1;

    snd_mailbox #(.DATA_W(8), .DEPTH(4), .LATCH_MODE(1'b0), .AUTO_IRQ(1'b0)) dut (
        .main_clk    (main_clk),
        .reset       (reset),
        .snd_dt      (snd_dt),
        .snd_on      (snd_on),
        .snd_din     (snd_din),
        .z80_rd      (z80_rd),
        .z80_iorq_n  (z80_iorq_n),
        .z80_dout    (z80_dout),
        .z80_int_n   (z80_int_n),
        .cmd_count   (cmd_count),
        .overflow    (overflow),
        .reply_wr    (reply_wr),
        .reply_din   (reply_din),
        .reply_rd    (reply_rd),
        .reply_dout  (reply_dout),
        .reply_valid (reply_valid)
    );

    snd_mailbox #(.DATA_W(8), .DEPTH(4), .LATCH_MODE(1'b1), .AUTO_IRQ(1'b1)) dut_latch (
        .main_clk    (main_clk),
        .reset       (reset),
        .snd_dt      (l_dt),
        .snd_on      (snd_on),
        .snd_din     (snd_din),
        .z80_rd      (l_rd),
        .z80_iorq_n  (z80_iorq_n),
        .z80_dout    (l_dout),
        .z80_int_n   (l_int_n),
        .cmd_count   (l_count),
        .overflow    (l_overflow),
        .reply_wr    (reply_wr),
        .reply_din   (reply_din),
        .reply_rd    (reply_rd),
        .reply_dout  (l_reply_dout),
        .reply_valid (l_reply_valid)
    );

    function automatic int unsigned read_kind(input int k);
        case (k)
            K_DOUT:   return {24'd0, z80_dout};
            K_COUNT:  return {29'd0, cmd_count};
            K_OVF:    return {31'd0, overflow};
            K_INTN:   return {31'd0, z80_int_n};
            K_RDOUT:  return {24'd0, reply_dout};
            K_RVALID: return {31'd0, reply_valid};
            K_LDOUT:  return {24'd0, l_dout};
            K_LCOUNT: return {29'd0, l_count};
            K_LOVF:   return {31'd0, l_overflow};
            K_LINTN:  return {31'd0, l_int_n};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Retire every expectation that has come due, away from the active edge.
    always @(negedge main_clk) begin
        int          k;
        int unsigned v;
        int unsigned act;
        string       n;
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            k = kind_q.pop_front();
            v = val_q.pop_front();
            void'(due_q.pop_front());
            n = name_q.pop_front();
            act = read_kind(k);
            checks++;
            if (act !== v) begin
                errors++;
                $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", n, act, v);
            end
        end
    end

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic expect_val(input int k, input int unsigned v, input string n);
        kind_q.push_back(k);
        val_q.push_back(v);
        due_q.push_back(cyc);
        name_q.push_back(n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push_cmd(input logic [7:0] d);
        snd_din = d;
        snd_dt  = 1'b1;
        tick();
        snd_dt  = 1'b0;
        tick();
    endtask

    task automatic pop_cmd();
        z80_rd = 1'b1;
        tick();
        z80_rd = 1'b0;
        tick();
    endtask

    task automatic latch_push(input logic [7:0] d);
        snd_din = d;
        l_dt    = 1'b1;
        tick();
        l_dt    = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        expect_val(K_COUNT, 0, "reset_count");
        expect_val(K_OVF, 0, "reset_overflow");
        expect_val(K_INTN, 1, "reset_int_n");
        expect_val(K_DOUT, 0, "reset_dout");
        expect_val(K_RVALID, 0, "reset_reply_valid");
        expect_val(K_RDOUT, 0, "reset_reply_dout");

        // Basic FIFO order and hold-on-empty
        push_cmd(8'h11);
        push_cmd(8'h22);
        push_cmd(8'h33);
        expect_val(K_COUNT, 3, "three_push_count");
        expect_val(K_DOUT, 8'h11, "three_push_head");
        pop_cmd();
        expect_val(K_DOUT, 8'h22, "pop1_head");
        pop_cmd();
        expect_val(K_DOUT, 8'h33, "pop2_head");
        pop_cmd();
        expect_val(K_COUNT, 0, "pop3_count");
        expect_val(K_DOUT, 8'h33, "pop3_hold");
        pop_cmd();
        expect_val(K_COUNT, 0, "empty_pop_count");
        expect_val(K_DOUT, 8'h33, "empty_pop_hold");
        expect_val(K_OVF, 0, "no_overflow_yet");

        // Overflow: the fifth push is lost
        for (int i = 1; i <= 5; i++) push_cmd(8'(i));
        expect_val(K_COUNT, 4, "ovf_count");
        expect_val(K_OVF, 1, "ovf_flag");
        for (int i = 1; i <= 4; i++) begin
            expect_val(K_DOUT, i, "ovf_drain_head");
            pop_cmd();
        end
        expect_val(K_COUNT, 0, "ovf_drained_count");
        expect_val(K_OVF, 1, "ovf_sticky");

        // Push and pop together at full
        do_reset();
        expect_val(K_OVF, 0, "ovf_cleared_by_reset");
        for (int i = 1; i <= 4; i++) push_cmd(8'h40 + 8'(i));
        snd_din = 8'h77;
        snd_dt  = 1'b1;
        z80_rd  = 1'b1;
        tick();
        snd_dt  = 1'b0;
        z80_rd  = 1'b0;
        tick();
        expect_val(K_COUNT, 4, "full_pushpop_count");
        expect_val(K_OVF, 0, "full_pushpop_no_ovf");
        expect_val(K_DOUT, 8'h42, "full_pushpop_head");
        pop_cmd();
        expect_val(K_DOUT, 8'h43, "full_pp_second");
        pop_cmd();
        expect_val(K_DOUT, 8'h44, "full_pp_third");
        pop_cmd();
        expect_val(K_DOUT, 8'h77, "full_pp_fourth");
        pop_cmd();
        expect_val(K_COUNT, 0, "full_pp_drained");

        // IRQ trigger and acknowledge priority
        snd_on = 1'b1;
        tick();
        expect_val(K_INTN, 0, "irq_on_rise");
        snd_on = 1'b0;
        tick();
        expect_val(K_INTN, 0, "irq_held");
        snd_on = 1'b1;
        z80_iorq_n = 1'b0;
        tick();
        expect_val(K_INTN, 1, "ack_beats_trigger");
        snd_on = 1'b0;
        z80_iorq_n = 1'b1;
        tick();
        expect_val(K_INTN, 1, "irq_stays_clear");

        // Reply path
        reply_din = 8'h5A;
        reply_wr  = 1'b1;
        tick();
        reply_wr  = 1'b0;
        expect_val(K_RDOUT, 8'h5A, "reply_data");
        expect_val(K_RVALID, 1, "reply_valid_set");
        reply_rd = 1'b1;
        tick();
        reply_rd = 1'b0;
        expect_val(K_RVALID, 0, "reply_valid_clr");
        expect_val(K_RDOUT, 8'h5A, "reply_data_kept");
        reply_din = 8'hC3;
        reply_wr  = 1'b1;
        reply_rd  = 1'b1;
        tick();
        reply_wr  = 1'b0;
        reply_rd  = 1'b0;
        expect_val(K_RDOUT, 8'hC3, "reply_wr_rd_data");
        expect_val(K_RVALID, 1, "reply_wr_rd_valid");

        // Reset mid-operation with strobes held high
        push_cmd(8'hA1);
        push_cmd(8'hA2);
        push_cmd(8'hA3);
        expect_val(K_COUNT, 3, "pre_reset_count");
        snd_on = 1'b1;
        tick();
        expect_val(K_INTN, 0, "pre_reset_irq");
        snd_dt = 1'b1;
        reset  = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        tick();
        tick();
        expect_val(K_COUNT, 0, "held_dt_no_push");
        expect_val(K_INTN, 1, "held_on_no_irq");
        expect_val(K_DOUT, 0, "reset_mid_dout");
        snd_dt = 1'b0;
        snd_on = 1'b0;
        tick();
        expect_val(K_COUNT, 0, "dt_low_no_push");
        push_cmd(8'hA4);
        expect_val(K_COUNT, 1, "rearmed_push_count");
        expect_val(K_DOUT, 8'hA4, "rearmed_push_head");

        // Latch mode with automatic IRQ
        do_reset();
        expect_val(K_LINTN, 1, "latch_reset_int_n");
        expect_val(K_LCOUNT, 0, "latch_reset_count");
        latch_push(8'hAA);
        expect_val(K_LINTN, 0, "latch_auto_irq");
        latch_push(8'hBB);
        expect_val(K_LDOUT, 8'hBB, "latch_overwrite");
        expect_val(K_LCOUNT, 1, "latch_count_one");
        expect_val(K_LOVF, 0, "latch_no_ovf");
        l_rd = 1'b1;
        tick();
        l_rd = 1'b0;
        tick();
        expect_val(K_LCOUNT, 0, "latch_pop_count");
        expect_val(K_LDOUT, 8'hBB, "latch_pop_keeps");

        for (int i = 0; i < 20 && due_q.size() > 0; i++) tick();
        if (due_q.size() > 0) begin
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0 pending", due_q.size());
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snd_mailbox.md
SND_MAILBOX -- requirements
Module: snd_mailbox

Interface
REQ-001 Parameter DATA_W, default 8: width of command and reply bytes.
REQ-002 Parameter DEPTH, default 4, power of 2 (minimum 2): command FIFO depth.
REQ-003 Parameter LATCH_MODE, default 0: 1 selects a single overwrite latch of legacy behaviour; 0 selects FIFO.
REQ-004 Parameter AUTO_IRQ, default 0: 1 makes every accepted push also trigger the Z80 IRQ.
REQ-005 main_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 snd_dt  in  1  68K command strobe, level; a rising edge pushes snd_din.
REQ-008 snd_on  in  1  68K IRQ request, level; a rising edge triggers the Z80 IRQ.
REQ-009 snd_din  in  DATA_W  68K command data.
REQ-010 z80_rd  in  1  one-cycle pop strobe from the Z80 comm-register read decode.
REQ-011 z80_iorq_n  in  1  Z80 IORQ, active low; any low cycle acknowledges the IRQ.
REQ-012 z80_dout  out  DATA_W  head of queue (show-ahead).
REQ-013 z80_int_n  out  1  Z80 interrupt, active low.
REQ-014 cmd_count  out  $clog2(DEPTH)+1  number of queued commands.
REQ-015 overflow  out  1  sticky flag: a push was lost.
REQ-016 reply_wr  in  1  one-cycle Z80 reply write strobe; reply_din  in  DATA_W  reply data.
REQ-017 reply_rd  in  1  one-cycle 68K reply read strobe; reply_dout  out  DATA_W; reply_valid  out  1.

Function
REQ-018 Edge detect: snd_dt and snd_on shall each be registered once; a rising edge is prev=0, cur=1, and it acts in the same cycle as cur is sampled.
REQ-019 FIFO mode: a push when not full shall write snd_din at the tail, and cmd_count shall increment on the next edge.
REQ-020 FIFO mode: a push when full (count==DEPTH) shall be dropped, overflow shall set, and the contents shall be unchanged.
REQ-021 FIFO mode: z80_rd when count>0 shall advance the head, and count shall decrement.
REQ-022 FIFO mode: z80_rd when empty shall be ignored, and z80_dout shall hold its last value.
REQ-023 Simultaneous push and pop with 0<count<DEPTH: both shall take effect, and count shall be unchanged.
REQ-024 Simultaneous push and pop at count==DEPTH: both shall take effect, with no overflow.
REQ-025 Simultaneous push and pop at count==0: only the push shall take effect.
REQ-026 Pointers shall be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-027 z80_dout shall equal mem[rd_ptr] in every cycle; it shall be registered or a RAM read, settling one cycle after any pointer or write change.
REQ-028 LATCH_MODE=1: a push shall overwrite the single entry and set count to 1; overflow shall never set.
REQ-029 LATCH_MODE=1: a pop shall clear count to 0, and z80_dout shall keep the data.
REQ-030 IRQ: z80_int_n shall go low the cycle after an snd_on rising edge, or after an accepted push when AUTO_IRQ=1.
REQ-031 IRQ: z80_int_n shall go high the cycle after any cycle in which z80_iorq_n is low.
REQ-032 Acknowledge shall have priority over a trigger in the same cycle.
REQ-033 Reply: reply_wr shall load reply_din into reply_dout and set reply_valid.
REQ-034 Reply: reply_rd shall clear reply_valid.
REQ-035 Reply: reply_wr and reply_rd in the same cycle shall load the new data and leave reply_valid=1.

Reset
REQ-036 On reset: pointers=0, cmd_count=0, overflow=0, z80_int_n=1, z80_dout=0, reply_dout=0, reply_valid=0, and edge registers=0.
REQ-037 Reset shall override all strobes in the same cycle and discard queued data mid-operation.
REQ-038 A level held high on snd_dt or snd_on across reset release shall not generate an edge until it has gone low and then high again.
REQ-039 overflow shall clear only on reset.

Structure
REQ-040 Package snd_pkg shall hold the DATA_W default, the $clog2 helper constants, and the comm-register address decode constant 4'b1010.
REQ-041 One sub-module, snd_fifo (parametrised storage plus pointers and count), shall be instantiated when LATCH_MODE=0.
REQ-042 Edge detection, IRQ, latch mode and the reply path shall stay in snd_mailbox.

Verification
REQ-043 DEPTH=4: push 0x11,0x22,0x33 -> cmd_count=3, z80_dout=0x11; three pops -> outputs 0x22, 0x33, then count=0 with z80_dout holding 0x33.
REQ-044 DEPTH=4: five pushes 0x01..0x05 -> count=4, overflow=1; four pops -> data 0x01..0x04, 0x05 absent.
REQ-045 snd_on rise -> z80_int_n=0 on the next cycle; z80_iorq_n low coincident with a second snd_on rise -> z80_int_n=1.
REQ-046 LATCH_MODE=1: push 0xAA then 0xBB -> z80_dout=0xBB, count=1; pop -> count=0, z80_dout=0xBB.
REQ-047 count=4 with simultaneous push 0x77 and pop -> count stays 4, overflow=0, and 0x77 is read fourth.
REQ-048 Reset asserted with count=3 and snd_dt held high -> count=0, z80_int_n=1, and no push after release until snd_dt toggles.
